win_check: RTL
==============

WIN_CHECK -- requirements
Module: win_check

Interface
REQ-001 SHALL have parameter ROWS, default 6: board rows.
REQ-002 SHALL have parameter COLS, default 7: board columns.
REQ-003 SHALL have parameter WIN_LEN, default 4: run length that wins.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous reset, active-low (rst=0 resets).
REQ-006 SHALL have port grid, input, 84: board from the game controller, grid[83:0].
REQ-007 SHALL have port term, output, 1: game over; sticky; fed back to the game controller.
REQ-008 SHALL have port winner, output, 2: 01 = player 1, 10 = player 2, 11 = draw, 00 = none.
REQ-009 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-010 SHALL have port done, output, 1: one-cycle pulse when term rises.

Function
REQ-011 SHALL decode each cell as 2 bits: 00 empty, 01 player 1, 10 player 2, 11 invalid.
- Cell (r,c) sits at msb index 14r+13-2c; r=0 is the bottom row; c=0 is the left column.
REQ-012 SHALL keep registers prev[83:0] (last checked board) and snap[83:0] (board under check).
- Also keeps row/col position, origin row/col, color, run[2:0], dir[1:0], sense.
REQ-013 SHALL use states IDLE, FIND, PROBE, DONE.
REQ-014 IDLE, board cleared: if grid==0, SHALL clear term, winner and prev, and stay in IDLE.
REQ-015 IDLE, board changed: if term==0, grid!=0 and grid!=prev, SHALL latch snap<=grid, set the scan index to cell (0,0), and go to FIND next cycle.
REQ-016 IDLE, game over: while term==1, SHALL ignore every grid change except the all-zero clear.
REQ-017 FIND SHALL examine one cell per cycle in row-major order, (0,0) first.
- Cell equal in snap and prev: advance to the next cell.
- Cell differs: copy it into prev. If it is 01/10: latch color, origin=cell, run=1, dir=0, sense=+, and go to PROBE. If it is 00/11: go to IDLE.
- No differing cell found after the last cell: go to IDLE.
REQ-018 PROBE SHALL test one neighbour per cycle. Deltas (dc,dr) by dir: 0=(1,0), 1=(0,1), 2=(1,1), 3=(1,-1). Sense '-' negates the delta.
REQ-019 PROBE neighbour in bounds and equal to color: SHALL increment run and step to that neighbour.
- Reaching run==WIN_LEN: go to DONE with winner=color.
REQ-020 PROBE neighbour off-board or not equal to color: SHALL switch direction.
- Sense '+': switch to sense '-' and restart from origin.
- Sense '-': go to dir+1, run=1, sense '+'.
REQ-021 When dir 3 sense '-' fails: if no cell of snap is 00, SHALL go to DONE with winner=11; otherwise return to IDLE.
REQ-022 DONE SHALL set term=1 and winner, pulse done for exactly one cycle, then return to IDLE.
REQ-023 Multiple cells changing at once SHALL be handled one cell per FIND/PROBE pass. prev is updated per cell, so the remaining differences retrigger from IDLE.
REQ-024 Grid changes while busy SHALL NOT affect the scan in progress, which uses snap only. They are picked up on the next IDLE comparison.
REQ-025 Latency from grid change to term SHALL be at most 1 + ROWS*COLS + 2*4*(WIN_LEN-1) + 1 cycles, i.e. 68 with default parameters.

Reset
REQ-026 rst=0 SHALL asynchronously force state=IDLE, term=0, winner=00, done=0, busy=0, prev=0, snap=0, and all counters to 0.
REQ-027 Reset asserted mid-scan SHALL abort the scan. After release, a non-zero grid SHALL trigger a fresh full check from IDLE.

Structure
REQ-028 A shared package connect4_pkg SHALL hold:
- ROWS, COLS, WIN_LEN
- cell codes EMPTY/P1/P2
- the cell-index function (14r+13-2c)
- the state enumeration
- the direction delta table
REQ-029 The cell read from snap by (row,col) SHALL be a combinational sub-module grid_cell_mux, used for both FIND and PROBE.

Verification
REQ-030 Horizontal win: P1 placed at (0,0),(0,1),(0,2),(0,3) one per 100 cycles. Required: term=1, winner=01, done pulse after the last placement only.
REQ-031 Vertical win: P2 at (0,6),(1,6),(2,6),(3,6). Required: winner=10, term within 68 cycles of the last change.
REQ-032 Diagonal with gap: P1 at (0,0),(1,1),(3,3), then (2,2) added last. Required: no term before (2,2); winner=01 after it (origin in the middle, both senses counted).
REQ-033 Draw: fill all 42 cells in a no-four pattern. Required: winner=11, term=1; a later grid=0 clears term and winner.
REQ-034 Reset and simultaneous change: rst=0 pulsed during PROBE, then released with a 4-in-row board. Required: outputs 0 during reset, then term=1 after the rescan. Two cells changed in one cycle are both checked.

Source files
------------

// File: rtl/connect4_pkg.sv
// Shared board geometry, cell codes, checker states and direction table for
// the Connect-4 win checker.
package connect4_pkg;

    localparam int unsigned ROWS    = 6;
    localparam int unsigned COLS    = 7;
    localparam int unsigned WIN_LEN = 4;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] P1    = 2'b01;
    localparam logic [1:0] P2    = 2'b10;
    localparam logic [1:0] DRAW  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIND  = 2'd1,
        PROBE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // MSB of cell (r,c); row 0 is the bottom row, column 0 the left column.
    function automatic int unsigned cell_msb(input int unsigned r, input int unsigned c,
                                             input int unsigned cols);
        return 2 * cols * r + 2 * cols - 1 - 2 * c;
    endfunction

    // Column step per direction: horizontal, vertical, rising and falling diagonal.
    function automatic int dir_dc(input logic [1:0] dir);
        int dc;
        case (dir)
            2'd0:    dc = 1;
            2'd1:    dc = 0;
            2'd2:    dc = 1;
            default: dc = 1;
        endcase
        return dc;
    endfunction

    // Row step per direction.
    function automatic int dir_dr(input logic [1:0] dir);
        int dr;
        case (dir)
            2'd0:    dr = 0;
            2'd1:    dr = 1;
            2'd2:    dr = 1;
            default: dr = -1;
        endcase
        return dr;
    endfunction

endpackage

// File: rtl/grid_cell_mux.sv
// Combinational read of one 2-bit cell from a packed board by (row, col).
module grid_cell_mux import connect4_pkg::*; #(
    parameter  int unsigned ROWS   = connect4_pkg::ROWS,
    parameter  int unsigned COLS   = connect4_pkg::COLS,
    localparam int unsigned GRID_W = 2 * ROWS * COLS,
    localparam int unsigned IDX_W  = $clog2(GRID_W),
    localparam int unsigned ROW_W  = $clog2(ROWS),
    localparam int unsigned COL_W  = $clog2(COLS)
) (
    input  logic [GRID_W-1:0] i_grid,
    input  logic [ROW_W-1:0]  i_row,
    input  logic [COL_W-1:0]  i_col,
    output logic [1:0]        o_cell
);

    logic [IDX_W-1:0] w_lsb;

    always_comb begin
        w_lsb  = IDX_W'(cell_msb(32'(i_row), 32'(i_col), COLS) - 1);
        o_cell = i_grid[w_lsb +: 2];
    end

endmodule

// File: rtl/win_check.sv
// Incremental Connect-4 judge: finds the newly placed cell, walks its four
// lines in both senses and reports a win, a draw or nothing.
module win_check import connect4_pkg::*; #(
    parameter  int unsigned ROWS    = connect4_pkg::ROWS,
    parameter  int unsigned COLS    = connect4_pkg::COLS,
    parameter  int unsigned WIN_LEN = connect4_pkg::WIN_LEN,
    localparam int unsigned GRID_W  = 2 * ROWS * COLS,
    localparam int unsigned IDX_W   = $clog2(GRID_W),
    localparam int unsigned ROW_W   = $clog2(ROWS),
    localparam int unsigned COL_W   = $clog2(COLS),
    localparam int unsigned RUN_W   = $clog2(WIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [GRID_W-1:0] grid,
    output logic              term,
    output logic [1:0]        winner,
    output logic              busy,
    output logic              done
);

    state_e             r_state, w_state_nxt;
    logic [GRID_W-1:0]  r_prev, w_prev_nxt;
    logic [GRID_W-1:0]  r_snap, w_snap_nxt;
    logic [ROW_W-1:0]   r_row, w_row_nxt, r_org_row, w_org_row_nxt;
    logic [COL_W-1:0]   r_col, w_col_nxt, r_org_col, w_org_col_nxt;
    logic [1:0]         r_color, w_color_nxt;
    logic [RUN_W-1:0]   r_run, w_run_nxt;
    logic [1:0]         r_dir, w_dir_nxt;
    logic               r_sense, w_sense_nxt;
    logic               r_term, w_term_nxt;
    logic [1:0]         r_winner, w_winner_nxt;
    logic               r_busy, r_done, w_done_nxt;

    int                 w_dc, w_dr, w_nrow, w_ncol;
    logic               w_nbr_ok;
    logic [ROW_W-1:0]   w_nbr_row, w_addr_row;
    logic [COL_W-1:0]   w_nbr_col, w_addr_col;
    logic [1:0]         w_snap_cell, w_prev_cell;
    logic [IDX_W-1:0]   w_cur_lsb;
    logic               w_last_cell;
    logic               w_full;
    logic [ROWS*COLS-1:0] w_empty;

    // Neighbour of the current probe position; r_sense=1 walks the negative way.
    always_comb begin
        w_dc = dir_dc(r_dir);
        w_dr = dir_dr(r_dir);
        if (r_sense) begin
            w_dc = -w_dc;
            w_dr = -w_dr;
        end
        w_nrow    = int'(r_row) + w_dr;
        w_ncol    = int'(r_col) + w_dc;
        w_nbr_ok  = (w_nrow >= 0) && (w_nrow < int'(ROWS)) &&
                    (w_ncol >= 0) && (w_ncol < int'(COLS));
        w_nbr_row = w_nbr_ok ? ROW_W'(w_nrow) : r_row;
        w_nbr_col = w_nbr_ok ? COL_W'(w_ncol) : r_col;
    end

    always_comb begin
        w_addr_row  = (r_state == PROBE) ? w_nbr_row : r_row;
        w_addr_col  = (r_state == PROBE) ? w_nbr_col : r_col;
        w_cur_lsb   = IDX_W'(cell_msb(32'(r_row), 32'(r_col), COLS) - 1);
        w_last_cell = (r_row == ROW_W'(ROWS - 1)) && (r_col == COL_W'(COLS - 1));
    end

    grid_cell_mux #(.ROWS(ROWS), .COLS(COLS)) u_snap_mux (
        .i_grid (r_snap),
        .i_row  (w_addr_row),
        .i_col  (w_addr_col),
        .o_cell (w_snap_cell)
    );

    grid_cell_mux #(.ROWS(ROWS), .COLS(COLS)) u_prev_mux (
        .i_grid (r_prev),
        .i_row  (r_row),
        .i_col  (r_col),
        .o_cell (w_prev_cell)
    );

    // Draw detection: 11 cells count as occupied.
    for (genvar g = 0; g < int'(ROWS * COLS); g++) begin : g_empty
        assign w_empty[g] = (r_snap[2*g +: 2] == EMPTY);
    end
    assign w_full = ~|w_empty;

    always_comb begin
        w_state_nxt   = r_state;
        w_prev_nxt    = r_prev;
        w_snap_nxt    = r_snap;
        w_row_nxt     = r_row;
        w_col_nxt     = r_col;
        w_org_row_nxt = r_org_row;
        w_org_col_nxt = r_org_col;
        w_color_nxt   = r_color;
        w_run_nxt     = r_run;
        w_dir_nxt     = r_dir;
        w_sense_nxt   = r_sense;
        w_term_nxt    = r_term;
        w_winner_nxt  = r_winner;
        w_done_nxt    = 1'b0;

        case (r_state)
            IDLE: begin
                if (grid == '0) begin
                    w_term_nxt   = 1'b0;
                    w_winner_nxt = 2'b00;
                    w_prev_nxt   = '0;
                end else if (!r_term && (grid != r_prev)) begin
                    w_snap_nxt  = grid;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                    w_state_nxt = FIND;
                end
            end

            FIND: begin
                if (w_snap_cell != w_prev_cell) begin
                    w_prev_nxt[w_cur_lsb +: 2] = w_snap_cell;
                    if ((w_snap_cell == P1) || (w_snap_cell == P2)) begin
                        w_color_nxt   = w_snap_cell;
                        w_org_row_nxt = r_row;
                        w_org_col_nxt = r_col;
                        w_run_nxt     = RUN_W'(1);
                        w_dir_nxt     = 2'd0;
                        w_sense_nxt   = 1'b0;
                        w_state_nxt   = PROBE;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_last_cell) begin
                    w_state_nxt = IDLE;
                end else if (r_col == COL_W'(COLS - 1)) begin
                    w_col_nxt = '0;
                    w_row_nxt = r_row + ROW_W'(1);
                end else begin
                    w_col_nxt = r_col + COL_W'(1);
                end
            end

            PROBE: begin
                if (w_nbr_ok && (w_snap_cell == r_color)) begin
                    w_run_nxt = r_run + RUN_W'(1);
                    w_row_nxt = w_nbr_row;
                    w_col_nxt = w_nbr_col;
                    if (r_run == RUN_W'(WIN_LEN - 1)) begin
                        w_term_nxt   = 1'b1;
                        w_winner_nxt = r_color;
                        w_done_nxt   = 1'b1;
                        w_state_nxt  = DONE;
                    end
                end else if (!r_sense) begin
                    // Keep the run: the opposite sense extends the same line.
                    w_sense_nxt = 1'b1;
                    w_row_nxt   = r_org_row;
                    w_col_nxt   = r_org_col;
                end else if (r_dir == 2'd3) begin
                    if (w_full) begin
                        w_term_nxt   = 1'b1;
                        w_winner_nxt = DRAW;
                        w_done_nxt   = 1'b1;
                        w_state_nxt  = DONE;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_dir_nxt   = r_dir + 2'd1;
                    w_run_nxt   = RUN_W'(1);
                    w_sense_nxt = 1'b0;
                    w_row_nxt   = r_org_row;
                    w_col_nxt   = r_org_col;
                end
            end

            DONE: begin
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_prev    <= '0;
            r_snap    <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_org_row <= '0;
            r_org_col <= '0;
            r_color   <= 2'b00;
            r_run     <= '0;
            r_dir     <= 2'd0;
            r_sense   <= 1'b0;
            r_term    <= 1'b0;
            r_winner  <= 2'b00;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_prev    <= w_prev_nxt;
            r_snap    <= w_snap_nxt;
            r_row     <= w_row_nxt;
            r_col     <= w_col_nxt;
            r_org_row <= w_org_row_nxt;
            r_org_col <= w_org_col_nxt;
            r_color   <= w_color_nxt;
            r_run     <= w_run_nxt;
            r_dir     <= w_dir_nxt;
            r_sense   <= w_sense_nxt;
            r_term    <= w_term_nxt;
            r_winner  <= w_winner_nxt;
            r_busy    <= (w_state_nxt != IDLE);
            r_done    <= w_done_nxt;
        end
    end

    assign term   = r_term;
    assign winner = r_winner;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule
